// File: rtl/exception_unit_if.sv
// exception_unit_if: decoder/interrupt/redirect bundle between the decode stage and exception_unit.
interface exception_unit_if;
  logic        instr_valid;
  logic        NotAnInstr;
  logic        ERet;
  logic [63:0] pc_dec;
  logic        irq_req;
  logic [1:0]  sysreg_sel;
  logic        Exc;
  logic [63:0] ExcPC;
  logic        flush;
  logic        irq_ack;
  logic        in_handler;
  logic        halt;
  logic [63:0] sysreg_rd;
  modport master (
    output instr_valid, NotAnInstr, ERet, pc_dec, irq_req, sysreg_sel,
    input  Exc, ExcPC, flush, irq_ack, in_handler, halt, sysreg_rd
  );
  modport slave (
    input  instr_valid, NotAnInstr, ERet, pc_dec, irq_req, sysreg_sel,
    output Exc, ExcPC, flush, irq_ack, in_handler, halt, sysreg_rd
  );
endinterface

// File: rtl/exception_unit.sv
// exception_unit: exception entry/return FSM with ELR/ESR/count system registers.
// Define EXC_IRQ_EN to enable the external interrupt trigger and irq_ack.
module exception_unit #(
  parameter logic [63:0] EXC_VECTOR = 64'h0000_0000_0000_00D8,
  parameter int          CNT_W      = 8
) (
  input logic             clk,
  input logic             reset_n,
  exception_unit_if.slave bus
);
  typedef enum logic [2:0] {RUN, TAKE, HANDLER, RETURN, FAULT} state_t;
  state_t state_q, state_d;
  logic [63:0] elr_q, elr_d, exc_pc_q, exc_pc_d;
  logic [3:0] esr_q, esr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic exc_q, exc_d, flush_q, flush_d, ack_q, ack_d, hnd_q, hnd_d, halt_q, halt_d;
  logic irq, nai, eret;
`ifdef EXC_IRQ_EN
  assign irq = bus.irq_req;
`else
  assign irq = 1'b0;
`endif
  assign nai  = bus.instr_valid & bus.NotAnInstr;
  assign eret = bus.instr_valid & bus.ERet;
  always_comb begin
    state_d = state_q;
    elr_d   = elr_q;
    esr_d   = esr_q;
    cnt_d   = cnt_q;
    case (state_q)
      RUN: if (nai | eret | irq) begin
        state_d = TAKE;
        elr_d   = bus.pc_dec;
        esr_d   = nai ? 4'b0001 : eret ? 4'b0011 : 4'b0010;
        cnt_d   = &cnt_q ? cnt_q : cnt_q + CNT_W'(1);
      end
      TAKE:    state_d = HANDLER;
      HANDLER: if (eret) state_d = RETURN;
               else if (nai) begin
                 state_d = FAULT;
                 esr_d   = 4'b0100;
               end
      RETURN:  state_d = RUN;
      FAULT:   state_d = FAULT;
      default: state_d = RUN;
    endcase
    // Outputs are decoded from the next state so they register alongside it.
    exc_d    = (state_d == TAKE) || (state_d == RETURN);
    flush_d  = exc_d;
    exc_pc_d = state_d == TAKE ? EXC_VECTOR : state_d == RETURN ? elr_d : 64'd0;
    ack_d    = (state_d == TAKE) && (esr_d == 4'b0010);
    hnd_d    = (state_d == HANDLER) || (state_d == RETURN);
    halt_d   = state_d == FAULT;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= RUN;
      elr_q    <= '0;
      esr_q    <= '0;
      cnt_q    <= '0;
      exc_q    <= 1'b0;
      exc_pc_q <= '0;
      flush_q  <= 1'b0;
      ack_q    <= 1'b0;
      hnd_q    <= 1'b0;
      halt_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      elr_q    <= elr_d;
      esr_q    <= esr_d;
      cnt_q    <= cnt_d;
      exc_q    <= exc_d;
      exc_pc_q <= exc_pc_d;
      flush_q  <= flush_d;
      ack_q    <= ack_d;
      hnd_q    <= hnd_d;
      halt_q   <= halt_d;
    end
  end
  assign bus.Exc        = exc_q;
  assign bus.ExcPC      = exc_pc_q;
  assign bus.flush      = flush_q;
  assign bus.irq_ack    = ack_q;
  assign bus.in_handler = hnd_q;
  assign bus.halt       = halt_q;
  assign bus.sysreg_rd  = bus.sysreg_sel == 2'b00 ? elr_q :
                          bus.sysreg_sel == 2'b01 ? {60'd0, esr_q} :
                          bus.sysreg_sel == 2'b10 ? 64'(cnt_q) : 64'd0;
endmodule

// File: tb/tb_exception_unit.sv
// tb_exception_unit: directed vectors for exception_unit built with CNT_W=2.
module tb_exception_unit;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int n_cmp = 0;
  int n_err = 0;
  exception_unit_if bus();
  exception_unit #(.EXC_VECTOR(64'hD8), .CNT_W(2)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic drive(input logic v, input logic n, input logic e, input logic [63:0] pc, input logic irq);
    bus.instr_valid = v;
    bus.NotAnInstr  = n;
    bus.ERet        = e;
    bus.pc_dec      = pc;
    bus.irq_req     = irq;
    @(posedge clk);
    #2;
  endtask
  task automatic rd(input string tag, input logic [1:0] sel, input logic [63:0] exp);
    bus.sysreg_sel = sel;
    #1;
    check(tag, bus.sysreg_rd, exp);
  endtask
  task automatic outs(input string tag, input logic [5:0] exp, input logic [63:0] pc);
    check({tag, ".outs"}, {bus.Exc, bus.flush, bus.irq_ack, bus.in_handler, bus.halt, 1'b0}, exp);
    check({tag, ".excpc"}, bus.ExcPC, pc);
  endtask
  task automatic roundtrip(input logic [63:0] pc, input logic er, input logic [3:0] esr, input logic [1:0] cnt);
    drive(1, !er, er, pc, 0);
    outs("rt.take", 6'b110000, 64'hD8);
    rd("rt.elr", 2'd0, pc);
    rd("rt.esr", 2'd1, {60'd0, esr});
    rd("rt.cnt", 2'd2, {62'd0, cnt});
    drive(0, 0, 0, 0, 0);
    outs("rt.handler", 6'b000100, 0);
    drive(1, 0, 1, pc + 4, 0);
    outs("rt.return", 6'b110100, pc);
    drive(0, 0, 0, 0, 0);
    outs("rt.run", 6'b000000, 0);
  endtask
  initial begin
    bus.instr_valid = 0; bus.NotAnInstr = 0; bus.ERet = 0; bus.pc_dec = 0; bus.irq_req = 0; bus.sysreg_sel = 0;
    #2;
    outs("reset", 6'b000000, 0);
    rd("reset.elr", 2'd0, 0);
    rd("reset.sel3", 2'd3, 0);
    @(negedge clk);
    reset_n = 1'b1;
    drive(0, 0, 0, 0, 0);
    outs("idle", 6'b000000, 0);
    // undefined opcode, with a trigger presented during TAKE that must be ignored
    drive(1, 1, 0, 64'h40, 0);
    outs("nai.take", 6'b110000, 64'hD8);
    rd("nai.elr", 2'd0, 64'h40);
    rd("nai.esr", 2'd1, 1);
    rd("nai.cnt", 2'd2, 1);
    drive(1, 1, 0, 64'h99, 0);
    outs("nai.handler", 6'b000100, 0);
    rd("nai.esr_kept", 2'd1, 1);
    drive(1, 0, 1, 64'h44, 0);
    outs("nai.return", 6'b110100, 64'h40);
    drive(0, 0, 0, 0, 0);
    outs("nai.run", 6'b000000, 0);
    roundtrip(64'h50, 1, 4'd3, 2'd2);
    // simultaneous IRQ and undefined opcode: opcode wins
    drive(1, 1, 0, 64'h80, 1);
    outs("sim.take", 6'b110000, 64'hD8);
    rd("sim.esr", 2'd1, 1);
    rd("sim.cnt", 2'd2, 3);
    drive(0, 0, 0, 64'h84, 1);
    outs("sim.masked", 6'b000100, 0);
    drive(1, 0, 1, 64'h88, 1);
    outs("sim.return", 6'b110100, 64'h80);
    drive(0, 0, 0, 64'h90, 1);
    outs("sim.run", 6'b000000, 0);
    drive(0, 0, 0, 64'h90, 1);
`ifdef EXC_IRQ_EN
    outs("irq.take", 6'b111000, 64'hD8);
    rd("irq.esr", 2'd1, 2);
    rd("irq.elr", 2'd0, 64'h90);
    rd("irq.cnt_sat", 2'd2, 3);
    drive(0, 0, 0, 0, 0);
    outs("irq.ack_once", 6'b000100, 0);
    drive(1, 0, 1, 0, 0);
    outs("irq.return", 6'b110100, 64'h90);
    drive(0, 0, 0, 0, 0);
`else
    outs("irq.ignored", 6'b000000, 0);
    rd("irq.esr_kept", 2'd1, 1);
    drive(0, 0, 0, 0, 0);
`endif
    roundtrip(64'hA0, 0, 4'd1, 2'd3);
    roundtrip(64'hB0, 1, 4'd3, 2'd3);
    // double fault
    drive(1, 1, 0, 64'hC0, 0);
    drive(0, 0, 0, 0, 0);
    drive(1, 1, 0, 64'hC4, 0);
    outs("fault", 6'b000010, 0);
    rd("fault.esr", 2'd1, 4);
    rd("fault.elr", 2'd0, 64'hC0);
    drive(1, 0, 1, 64'hC8, 1);
    drive(0, 0, 0, 0, 0);
    outs("fault.sticky", 6'b000010, 0);
    reset_n = 1'b0;
    #1;
    outs("fault.reset", 6'b000000, 0);
    rd("fault.reset_esr", 2'd1, 0);
    @(negedge clk);
    reset_n = 1'b1;
    // asynchronous reset in the middle of TAKE
    drive(1, 1, 0, 64'h40, 0);
    outs("mid.take", 6'b110000, 64'hD8);
    reset_n = 1'b0;
    #1;
    outs("mid.reset", 6'b000000, 0);
    rd("mid.elr", 2'd0, 0);
    rd("mid.esr", 2'd1, 0);
    rd("mid.cnt", 2'd2, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/exception_unit.md
# exception_unit

Sequential exception controller sitting directly downstream of the main decoder. It consumes the decoder's `NotAnInstr` and `ERet` flags plus an external interrupt request. It captures the faulting or return PC into ELR and a cause code into ESR, and redirects fetch to a fixed vector with a pipeline flush. It also services `ERET` and drives the system-register read port used by `MRS`.

## Interface
Parameters:
- `EXC_VECTOR`, default 64'h0000_0000_0000_00D8: PC loaded on exception entry.
- `CNT_W`, default 8: width of the saturating exception counter.

Ports:
- `clk`  in  1  rising-edge clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `instr_valid`  in  1  decode-stage instruction valid this cycle; the flags below are ignored when low.
- `NotAnInstr`  in  1  decoder flag, undefined opcode.
- `ERet`  in  1  decoder flag, ERET instruction.
- `pc_dec`  in  64  PC of the instruction in decode.
- `irq_req`  in  1  external interrupt, level, held until `irq_ack`.
- `sysreg_sel`  in  2  MRS select: 00 ELR, 01 ESR, 10 count, 11 zero.
- `Exc`  out  1  redirect strobe.
- `ExcPC`  out  64  redirect target, valid when `Exc`=1.
- `flush`  out  1  squash IF/ID and ID/EX contents.
- `irq_ack`  out  1  one-cycle acknowledge.
- `in_handler`  out  1  high while in handler mode.
- `halt`  out  1  double fault, sticky until reset.
- `sysreg_rd`  out  64  MRS read data, combinational on `sysreg_sel`.

## Operation
State machine: RUN, TAKE, HANDLER, RETURN, FAULT.

- **Reset** (`reset_n`=0, asynchronous): the FSM goes to RUN. ELR=0, ESR=0, count=0. `Exc`, `ExcPC`, `flush`, `irq_ack`, `in_handler` and `halt` are all 0.
- **RUN**: triggers are evaluated in this priority order; the winning trigger moves the FSM to TAKE.
  - `instr_valid`&`NotAnInstr`: ELR←`pc_dec`, ESR←4'b0001.
  - `instr_valid`&`ERet`: illegal outside a handler. ELR←`pc_dec`, ESR←4'b0011.
  - `irq_req`: ELR←`pc_dec`, so the interrupted instruction re-executes. ESR←4'b0010.
  - Every trigger increments count, saturating at all-ones.
- **TAKE** (1 cycle):
  - `Exc`=1, `ExcPC`=`EXC_VECTOR`, `flush`=1.
  - `irq_ack`=1 only if the cause is IRQ.
  - Next state HANDLER.
- **HANDLER**:
  - `in_handler`=1 and `irq_req` is masked.
  - `instr_valid`&`ERet` → RETURN.
  - `instr_valid`&`NotAnInstr` → FAULT. ESR←4'b0100; ELR is unchanged.
- **RETURN** (1 cycle): `Exc`=1, `ExcPC`=ELR, `flush`=1, `in_handler`=1. Next state RUN.
- **FAULT**: `halt`=1 and all other outputs are 0. The only exit is reset.
- **sysreg_rd**: fields are zero-extended to 64 bits. It reflects register values as of the current cycle.

## Timing
- A trigger sampled at edge N produces TAKE outputs during cycle N+1, i.e. 1-cycle latency from trigger to redirect.
- ELR, ESR and count update at edge N, so they are already visible on `sysreg_rd` during TAKE.
- All outputs are registered-state decodes: Moore outputs, no combinational path from inputs.
  - Exception: `sysreg_rd` is combinational from `sysreg_sel`.
- Simultaneous triggers follow the RUN priority order.
  - An IRQ that loses stays pending because it is level; it is taken after the handler returns.
- Inputs arriving during TAKE or RETURN are ignored, since the flushed instruction is invalid.
- `irq_ack` is exactly 1 cycle. The source must deassert `irq_req` by cycle N+2. A request still high in RUN is taken as a new interrupt.
- Count at all-ones stays at all-ones; there is no wrap.
- Reset asserted mid-TAKE or mid-RETURN clears every output immediately (asynchronously).
- Reset deassertion is synchronized externally; the block only requires `reset_n` to meet recovery and removal timing to `clk`.

## Configuration
- `EXC_IRQ_EN` defined:
  - `irq_req` and `irq_ack` are present.
  - The IRQ trigger path and ESR code 4'b0010 are enabled.
- Not defined:
  - The ports still exist, but `irq_req` is ignored and `irq_ack` is tied to 0.
  - Only instruction-generated exceptions occur.

## Test plan
- Reset mid-operation: drive `NotAnInstr` with `pc_dec`=0x40 and assert `reset_n`=0 during TAKE. Required: all outputs 0 immediately; ELR=0, ESR=0, count=0.
- Undefined opcode: `pc_dec`=0x40 with `NotAnInstr`=1. Required next cycle: `Exc`=1, `ExcPC`=0xD8, `flush`=1. `sysreg_sel`=00 reads 0x40; `sysreg_sel`=01 reads 1. Then `in_handler`=1.
- Round trip: in HANDLER, `ERet`=1. Required: RETURN cycle with `ExcPC`=0x40 and `flush`=1, then RUN with `in_handler`=0.
- Simultaneous triggers (`EXC_IRQ_EN` defined): `irq_req` together with `NotAnInstr` at `pc_dec`=0x80. Required:
  - ESR=1 and `irq_ack`=0.
  - After ERET, the IRQ is taken: ESR=2, ELR=`pc_dec` of that cycle, `irq_ack` pulses once.
- Double fault: `NotAnInstr` while in HANDLER. Required: `halt`=1 sticky, ESR=4, ELR unchanged; holds until `reset_n`=0.
- Counter saturation: with `CNT_W`=2, apply 5 exception/return round trips. Required: count reads 3.
